alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Issue and capture stage wrapped around the 32-bit combinational ALU (opcodes OR, ADD, MIN, AND, SRL, SUB, SGE, SNE, PASSB). It buffers incoming ALU commands in a small FIFO and drives one command per cycle onto the ALU operand ports. It then registers the ALU result and flags into an output holding register with a valid/ready handshake toward writeback. The ALU stays purely combinational; this block supplies all pipelining and backpressure around it.

## Interface
- WIDTH, 32: operand/result width
- DEPTH, 4: command FIFO entries, power of two, at least 2
- TAG_W, 4: width of the opaque command tag carried through
- clk  in  1: single clock, rising edge
- rst_n  in  1: asynchronous, active-low reset
- in_valid  in  1: command valid
- in_ready  out  1: FIFO can accept a command (registered)
- in_opcode  in  4: ALU opcode
- in_a, in_b  in  WIDTH: operands
- in_shamt  in  5: shift amount
- in_tag  in  TAG_W: command tag
- alu_opcode  out  4: to ALU opcode
- alu_input1, alu_input2  out  WIDTH: to ALU operands
- alu_shiftValue  out  5: to ALU shiftValue
- alu_result  in  WIDTH: from ALU
- alu_carry, alu_zero, alu_sign  in  1: from ALU flags
- out_valid  out  1: captured result valid
- out_ready  in  1: consumer accepts
- out_result  out  WIDTH; out_carry, out_zero, out_sign  out  1; out_tag  out  TAG_W
- out_illegal  out  1: captured command had an unsupported opcode

## Operation
- Push: command written to FIFO tail when in_valid && in_ready.
- in_ready = 0 when FIFO count == DEPTH. No push-through-on-pop when full.
- Issue register: holds one command and drives the alu_* ports directly from flops. Loaded from the FIFO head when it is empty or retiring in the same cycle.
- Issue FSM:
  - IDLE: issue register empty; alu_* ports driven to 0. Moves to EXEC when the FIFO is non-empty.
  - EXEC: the ALU evaluates the issued command. At the clock edge the result is captured if the output register is empty or (out_valid && out_ready). If captured, the FSM reloads from the FIFO (stays in EXEC) or goes to IDLE when the FIFO is empty. If not captured, it goes to HOLD.
  - HOLD: the issue register and alu_* ports stay frozen. Capture occurs on the first cycle the output register frees, then the FSM follows the EXEC transition rules.
- Legal opcodes: 0–5 and 8. Opcodes 6, 7 (SGE/SNE, not implemented by the ALU) and 9–15 are illegal.
  - Illegal captures set out_illegal = 1 and force out_result = 0, out_carry = 0, out_zero = 1, out_sign = 0.
  - The command still completes and its tag is returned.
- Legal captures copy alu_result and the flags unmodified. out_tag = issued tag.
- Output register holds its contents stable while out_valid && !out_ready.

## Timing
- Reset (async assert, sync deassert): FIFO empty, in_ready = 1, FSM IDLE, alu_* = 0, out_valid = 0, all out_* = 0.
- Latency: command accepted at edge N is issued at edge N+1 (alu_* valid in cycle N+1) and captured at edge N+2, so out_valid is high in cycle N+2 at the earliest.
- Throughput: one command per cycle with out_ready held high and in_valid continuous.
- FIFO full with a push and a pop in the same cycle: the push is refused (in_ready already 0). in_ready rises the cycle after the pop.
- Empty FIFO with a simultaneous push: no bypass. The command issues the following cycle.
- Reset asserted mid-operation discards all queued, issued and captured commands immediately. No partial output.
- FIFO pointers wrap modulo DEPTH. A separate count register distinguishes full from empty.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams OR=0, ADD=1, MIN=2, AND=3, SRL=4, SUB=5, SGE=6, SNE=7, PASSB=8
  - the FSM state enum (IDLE, EXEC, HOLD)
  - an is_legal_op function
- Sub-module alu_cmd_fifo: parameterised synchronous FIFO with width 4+2*WIDTH+5+TAG_W and DEPTH entries, exporting full, empty and count.
- The ALU is instantiated in the parent, not inside this block.

## Test plan
- Single ADD: a = 0xFFFFFFFF, b = 1, tag 3, with the bench ALU model attached. Required: out_valid in cycle N+2, out_result = 0, out_zero = 1, out_tag = 3, out_illegal = 0.
- Streaming: 8 back-to-back SUB commands with out_ready = 1. Required: 8 consecutive out_valid cycles, results in order, tags 0–7 in order.
- Backpressure: hold out_ready = 0 while pushing 6 commands. Required:
  - in_ready drops after 4 FIFO entries plus the issue and output registers fill
  - alu_* stay frozen in HOLD
  - all 6 results drain in order once out_ready = 1
- Illegal opcode: opcode 7, a = 5, b = 9. Required: out_illegal = 1, out_result = 0, out_zero = 1, tag returned.
- SRL then PASSB: SRL with a = 0x80000000, shamt = 31, then PASSB with b = 0xDEADBEEF. Required: results 0x00000001 then 0xDEADBEEF, out_sign 0 then 1.
- Reset mid-stream: assert rst_n = 0 while 3 commands are in flight. Required: out_valid = 0 and in_ready = 1 immediately, and no stale result appears after release.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, issue FSM states and opcode legality for the ALU issue stage
package alu_pkg;

    localparam logic [3:0] OR    = 4'd0;
    localparam logic [3:0] ADD   = 4'd1;
    localparam logic [3:0] MIN   = 4'd2;
    localparam logic [3:0] AND   = 4'd3;
    localparam logic [3:0] SRL   = 4'd4;
    localparam logic [3:0] SUB   = 4'd5;
    localparam logic [3:0] SGE   = 4'd6;
    localparam logic [3:0] SNE   = 4'd7;
    localparam logic [3:0] PASSB = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } issue_state_t;

    // SGE/SNE have opcodes but the attached ALU does not implement them.
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= SUB) || (op == PASSB);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO with registered full/empty and an occupancy count
module alu_cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [W-1:0]                 wr_data,
    input  logic                         rd_en,
    output logic [W-1:0]                 rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_next;
    logic          do_wr;
    logic          do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_wr && !do_rd) begin
            count_next = count + CW'(1);
        end else if (!do_wr && do_rd) begin
            count_next = count - CW'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - buffers ALU commands, issues one per cycle and captures results toward writeback
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [4:0]       in_shamt,
    input  logic [TAG_W-1:0] in_tag,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [4:0]       alu_shiftValue,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_sign,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam int CMD_W = 4 + 2 * WIDTH + 5 + TAG_W;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CMD_W-1:0] head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [3:0]       h_op;
    logic [WIDTH-1:0] h_a;
    logic [WIDTH-1:0] h_b;
    logic [4:0]       h_sh;
    logic [TAG_W-1:0] h_tag;
    logic [TAG_W-1:0] iss_tag;
    issue_state_t     state;
    issue_state_t     state_next;
    logic             capture;
    logic             load;

    alu_cmd_fifo #(.W(CMD_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (in_valid && in_ready),
        .wr_data ({in_opcode, in_a, in_b, in_shamt, in_tag}),
        .rd_en   (load),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign {h_op, h_a, h_b, h_sh, h_tag} = head;
    assign in_ready = !fifo_full;

    // A non-zero occupancy is the issue trigger; empty is kept for consumers that prefer the flag.
    always_comb begin
        capture    = 1'b0;
        load       = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                load = (fifo_count != '0);
                if (load) state_next = EXEC;
            end
            EXEC, HOLD: begin
                capture = !out_valid || out_ready;
                load    = capture && !fifo_empty;
                if (!capture)   state_next = HOLD;
                else if (load)  state_next = EXEC;
                else            state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Issue register drives the ALU straight from flops; cleared when nothing follows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opcode     <= '0;
            alu_input1     <= '0;
            alu_input2     <= '0;
            alu_shiftValue <= '0;
            iss_tag        <= '0;
        end else if (load) begin
            alu_opcode     <= h_op;
            alu_input1     <= h_a;
            alu_input2     <= h_b;
            alu_shiftValue <= h_sh;
            iss_tag        <= h_tag;
        end else if (capture) begin
            alu_opcode     <= '0;
            alu_input1     <= '0;
            alu_input2     <= '0;
            alu_shiftValue <= '0;
            iss_tag        <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_carry   <= 1'b0;
            out_zero    <= 1'b0;
            out_sign    <= 1'b0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_tag   <= iss_tag;
            if (is_legal_op(alu_opcode)) begin
                out_result  <= alu_result;
                out_carry   <= alu_carry;
                out_zero    <= alu_zero;
                out_sign    <= alu_sign;
                out_illegal <= 1'b0;
            end else begin
                out_result  <= '0;
                out_carry   <= 1'b0;
                out_zero    <= 1'b1;
                out_sign    <= 1'b0;
                out_illegal <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed and randomized self-checking bench for alu_issue_stage
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_opcode = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [4:0]  in_shamt = '0;
    logic [3:0]  in_tag = '0;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_input1;
    logic [31:0] alu_input2;
    logic [4:0]  alu_shiftValue;
    logic [31:0] alu_result;
    logic        alu_carry;
    logic        alu_zero;
    logic        alu_sign;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_carry;
    logic        out_zero;
    logic        out_sign;
    logic [3:0]  out_tag;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [39:0] exp_q[$];
    int          pop_cyc[$];
    logic [31:0] got_res[$];
    logic        got_sign[$];

    alu_issue_stage #(.WIDTH(32), .DEPTH(4), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_a(in_a), .in_b(in_b), .in_shamt(in_shamt), .in_tag(in_tag),
        .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_shiftValue(alu_shiftValue), .alu_result(alu_result),
        .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_carry(out_carry), .out_zero(out_zero), .out_sign(out_sign),
        .out_tag(out_tag), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: {carry, result}; unsupported opcodes return junk that must never reach the output.
    function automatic logic [32:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
        logic [32:0] wide;
        case (op)
            4'd0: return {1'b0, a | b};
            4'd1: begin wide = {1'b0, a} + {1'b0, b}; return wide; end
            4'd2: return {1'b0, (a < b) ? a : b};
            4'd3: return {1'b0, a & b};
            4'd4: return {1'b0, a >> sh};
            4'd5: begin wide = {1'b0, a} - {1'b0, b}; return wide; end
            4'd8: return {1'b0, b};
            default: return {1'b1, 32'hBAD0_BAD0};
        endcase
    endfunction

    always_comb begin
        logic [32:0] r;
        r          = alu_fn(alu_opcode, alu_input1, alu_input2, alu_shiftValue);
        alu_result = r[31:0];
        alu_carry  = r[32];
        alu_zero   = (r[31:0] == 32'd0);
        alu_sign   = r[31];
    end

    // Expected writeback record {result, carry, zero, sign, tag, illegal}.
    function automatic logic [39:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh,
                                          input logic [3:0] tag);
        logic [32:0] r;
        if (!(op <= 4'd5 || op == 4'd8)) return {32'd0, 1'b0, 1'b1, 1'b0, tag, 1'b1};
        r = alu_fn(op, a, b, sh);
        return {r[31:0], r[32], r[31:0] == 32'd0, r[31], tag, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, want);
        end
    endtask

    // One clock: handshakes are judged at the falling edge, then we step just past the rising edge.
    task automatic tick();
        @(negedge clk);
        if (out_valid && out_ready) begin
            pop_cyc.push_back(cyc);
            got_res.push_back(out_result);
            got_sign.push_back(out_sign);
            if (exp_q.size() == 0) chk("unexpected_out", 64'(out_tag) | 64'h100, 64'h0);
            else chk("scoreboard", 64'({out_result, out_carry, out_zero, out_sign, out_tag, out_illegal}),
                     64'(exp_q.pop_front()));
        end
        if (in_valid && in_ready) exp_q.push_back(model(in_opcode, in_a, in_b, in_shamt, in_tag));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [3:0] tag);
        in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b; in_shamt = sh; in_tag = tag;
    endtask

    task automatic drain(input int max);
        int n = 0;
        in_valid = 1'b0;
        while (exp_q.size() > 0 && n < max) begin
            tick();
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        tick();
        tick();
    endtask

    initial begin
        logic [31:0] a_hist[$];
        logic [3:0]  t_hist[$];
        int acc;
        int guard;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_alu", 64'({alu_opcode, alu_input1, alu_shiftValue}), 64'd0);
        chk("rst_out", 64'({out_result, out_carry, out_zero, out_sign, out_tag, out_illegal}), 64'd0);

        // Single ADD: latency and carry-out wrap to zero.
        out_ready = 1'b1;
        drive(ADD, 32'hFFFF_FFFF, 32'd1, 5'd0, 4'd3);
        tick();
        in_valid = 1'b0;
        chk("add_no_bypass", 64'(alu_opcode), 64'(IDLE));
        chk("add_n1_out_valid", 64'(out_valid), 64'd0);
        tick();
        chk("add_issued", 64'({alu_opcode, alu_input1}), 64'({ADD, 32'hFFFF_FFFF}));
        chk("add_n1b_out_valid", 64'(out_valid), 64'd0);
        tick();
        chk("add_n2_out_valid", 64'(out_valid), 64'd1);
        chk("add_result", 64'({out_result, out_zero, out_tag, out_illegal}), 64'({32'd0, 1'b1, 4'd3, 1'b0}));
        drain(10);

        // Streaming SUB: one result per cycle.
        pop_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            drive(SUB, $urandom, $urandom, 5'($urandom), 4'(i));
            tick();
        end
        drain(20);
        chk("stream_count", 64'(pop_cyc.size()), 64'd8);
        if (pop_cyc.size() == 8) chk("stream_span", 64'(pop_cyc[7] - pop_cyc[0]), 64'd7);

        // Backpressure: capacity is FIFO + issue + output register.
        out_ready = 1'b0;
        acc = 0;
        guard = 0;
        while (acc < 6 && guard < 30) begin
            if (!in_valid || in_ready) begin
                a_hist.push_back($urandom);
                t_hist.push_back(4'($urandom));
                drive(ADD, a_hist[a_hist.size()-1], $urandom, 5'd0, t_hist[t_hist.size()-1]);
            end
            if (in_ready) acc++;
            tick();
            guard++;
        end
        chk("bp_accepted", 64'(acc), 64'd6);
        in_valid = 1'b0;
        tick();
        tick();
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_hold_a", 64'(alu_input1), 64'(a_hist[1]));
        repeat (3) tick();
        chk("bp_frozen_a", 64'(alu_input1), 64'(a_hist[1]));
        chk("bp_out_stable", 64'({out_valid, out_tag}), 64'({1'b1, t_hist[0]}));
        out_ready = 1'b1;
        drive(OR, $urandom, $urandom, 5'd0, 4'd9);
        chk("full_pop_refuse", 64'(in_ready), 64'd0);
        tick();
        chk("ready_after_pop", 64'(in_ready), 64'd1);
        tick();
        drain(30);

        // Illegal opcode is forced to a zero result but still returns its tag.
        drive(SNE, 32'd5, 32'd9, 5'd0, 4'hA);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("illegal_out", 64'({out_valid, out_illegal, out_result, out_zero, out_tag}),
            64'({1'b1, 1'b1, 32'd0, 1'b1, 4'hA}));
        drain(10);

        // SRL then PASSB.
        got_res.delete();
        got_sign.delete();
        drive(SRL, 32'h8000_0000, $urandom, 5'd31, 4'd1);
        tick();
        drive(PASSB, $urandom, 32'hDEAD_BEEF, 5'd0, 4'd2);
        tick();
        drain(10);
        chk("srl_pass_count", 64'(got_res.size()), 64'd2);
        if (got_res.size() == 2) begin
            chk("srl_result", 64'({got_res[0], got_sign[0]}), 64'({32'h0000_0001, 1'b0}));
            chk("passb_result", 64'({got_res[1], got_sign[1]}), 64'({32'hDEAD_BEEF, 1'b1}));
        end

        // Random opcodes and random backpressure.
        acc = 0;
        guard = 0;
        while (acc < 40 && guard < 2000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (!in_valid || in_ready) begin
                if ($urandom_range(0, 3) != 0)
                    drive(4'($urandom), $urandom, $urandom, 5'($urandom), 4'($urandom));
                else
                    in_valid = 1'b0;
            end
            if (in_valid && in_ready) acc++;
            tick();
            guard++;
        end
        chk("rand_accepted", 64'(acc), 64'd40);
        out_ready = 1'b1;
        drain(60);

        // Reset mid-stream discards everything in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(ADD, $urandom, $urandom, 5'd0, 4'(i));
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_alu", 64'({alu_opcode, alu_input2}), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        repeat (6) tick();
        chk("post_rst_idle", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
